// File: rtl/pmodstep_axil_pkg.sv
// Shared definitions for the PmodSTEP AXI4-Lite register slave: register
// offsets, response codes and the byte-lane merge used on writes.
package pmodstep_axil_pkg;

   localparam logic [4:0] REG_CTRL   = 5'h00;
   localparam logic [4:0] REG_PERIOD = 5'h04;
   localparam logic [4:0] REG_COUNT  = 5'h08;
   localparam logic [4:0] REG_AUX    = 5'h0C;
   localparam logic [4:0] REG_STATUS = 5'h10;

   // Word indices as seen on addr[4:2]
   localparam logic [2:0] IDX_CTRL   = REG_CTRL[4:2];
   localparam logic [2:0] IDX_AUX    = REG_AUX[4:2];
   localparam logic [2:0] IDX_STATUS = REG_STATUS[4:2];

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   function automatic logic [31:0] wstrb_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pmodstep_axil_slave_regs.sv
// AXI4-Lite slave holding the four PmodSTEP control registers and the start pulse.
// Optional read-only STATUS register at 0x10 when PMODSTEP_STATUS_REG_EN is defined.
module pmodstep_axil_slave_regs
   import pmodstep_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [31:0]                     ctrl_o,
   output logic [31:0]                     period_o,
   output logic [31:0]                     count_o,
   output logic [31:0]                     aux_o,
   output logic                            start_o,
   input  logic [31:0]                     status_i
);

   function automatic resp_t wr_resp(input logic [2:0] idx);
      if (idx <= IDX_AUX) return OKAY;
`ifdef PMODSTEP_STATUS_REG_EN
      if (idx == IDX_STATUS) return OKAY;
`endif
      return SLVERR;
   endfunction

   // write engine state
   logic        aw_held_q, aw_held_d;
   logic [2:0]  aw_idx_q, aw_idx_d;
   logic        w_held_q, w_held_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   resp_t       bresp_q, bresp_d;
   logic        start_q, start_d;
   logic [31:0] reg_q [4];
   logic [31:0] reg_d [4];

   // read engine state
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   resp_t       rresp_q, rresp_d;

   logic        aw_fire, w_fire, ar_fire, commit;

   assign aw_fire = s00_axi_awvalid & awready_q;
   assign w_fire  = s00_axi_wvalid & wready_q;
   assign ar_fire = s00_axi_arvalid & arready_q;

   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      start_d   = 1'b0;
      reg_d     = reg_q;
      commit    = 1'b0;

      if (aw_fire) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s00_axi_awaddr[4:2];
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         w_data_d = s00_axi_wdata;
         w_strb_d = s00_axi_wstrb;
      end

      // Both halves present (held or arriving this cycle) completes the write
      if (aw_held_d && w_held_d) begin
         commit    = 1'b1;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_resp(aw_idx_d);
         if (aw_idx_d <= IDX_AUX) begin
            reg_d[aw_idx_d[1:0]] = wstrb_merge(reg_q[aw_idx_d[1:0]], w_data_d, w_strb_d);
         end
         start_d = (aw_idx_d == IDX_CTRL) && w_strb_d[0] && w_data_d[0];
      end else if (bvalid_q && s00_axi_bready) begin
         bvalid_d = 1'b0;
      end

      awready_d = !aw_held_d && !bvalid_d;
      wready_d  = !w_held_d && !bvalid_d;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         start_q   <= 1'b0;
         for (int i = 0; i < 4; i++) reg_q[i] <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         start_q   <= start_d;
         for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
      end
   end

   // Reads sample reg_q, so a same-edge write is not visible to the read
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;

      if (ar_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = SLVERR;
         if (s00_axi_araddr[4:2] <= IDX_AUX) begin
            rdata_d = reg_q[s00_axi_araddr[3:2]];
            rresp_d = OKAY;
         end
`ifdef PMODSTEP_STATUS_REG_EN
         else if (s00_axi_araddr[4:2] == IDX_STATUS) begin
            rdata_d = status_i;
            rresp_d = OKAY;
         end
`endif
      end else if (rvalid_q && s00_axi_rready) begin
         rvalid_d = 1'b0;
      end

      arready_d = !rvalid_d;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = wready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = rresp_q;

   assign ctrl_o   = reg_q[0];
   assign period_o = reg_q[1];
   assign count_o  = reg_q[2];
   assign aux_o    = reg_q[3];
   assign start_o  = start_q;

   // Protection bits and byte offsets carry no meaning for this register map
   logic unused_ok;
`ifdef PMODSTEP_STATUS_REG_EN
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0], commit};
`else
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0], commit, status_i};
`endif

endmodule
